// File: rtl/led_sequence_player_if.sv
// Request/status and sequence-RAM read port of the LED sequence player.
// The slave modport is the player; the master side is the game FSM plus RAM.
interface led_sequence_player_if #(
    parameter int unsigned ADDR_W = 5
) ();
    logic              start;
    logic              abort;
    logic [ADDR_W:0]   len;
    logic [ADDR_W-1:0] rd_addr;
    logic [1:0]        rd_data;
    logic [3:0]        led;
    logic              busy;
    logic              done;

    modport master (
        output start, abort, len, rd_data,
        input  rd_addr, led, busy, done
    );

    modport slave (
        input  start, abort, len, rd_data,
        output rd_addr, led, busy, done
    );
endinterface

// File: rtl/led_sequence_player.sv
// Plays a stored Simon colour sequence as one-hot LED pulses with a dark gap
// between steps, reading colours from a one-cycle-latency sequence RAM.
module led_sequence_player #(
    parameter int unsigned ON_CYCLES  = 8,
    parameter int unsigned OFF_CYCLES = 4,
    parameter int unsigned ADDR_W     = 5
) (
    input logic                  clk,
    input logic                  rst_n,
    led_sequence_player_if.slave bus
);
    localparam int unsigned MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    // Counters run from N-1 down to 0 so a phase lasts exactly N cycles.
    localparam logic [CNT_W-1:0]  ON_LOAD  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0]  OFF_LOAD = CNT_W'(OFF_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W:0]   IDX_ONE  = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StData,
        StOn,
        StOff,
        StDone
    } state_e;

    state_e            r_state;
    state_e            w_state_d;
    logic [ADDR_W:0]   r_idx;
    logic [ADDR_W:0]   w_idx_d;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   w_len_d;
    logic [1:0]        r_colour;
    logic [1:0]        w_colour_d;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_d;
    logic              w_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_idx    <= '0;
            r_len    <= '0;
            r_colour <= '0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_d;
            r_idx    <= w_idx_d;
            r_len    <= w_len_d;
            r_colour <= w_colour_d;
            r_cnt    <= w_cnt_d;
        end
    end

    always_comb begin
        w_busy = (r_state == StAddr) || (r_state == StData) ||
                 (r_state == StOn)   || (r_state == StOff);
    end

    always_comb begin
        w_state_d  = r_state;
        w_idx_d    = r_idx;
        w_len_d    = r_len;
        w_colour_d = r_colour;
        w_cnt_d    = r_cnt;

        unique case (r_state)
            StIdle: begin
                if (bus.start) begin
                    if (bus.len != '0) begin
                        w_len_d   = bus.len;
                        w_idx_d   = '0;
                        w_state_d = StAddr;
                    end else begin
                        w_state_d = StDone;
                    end
                end
            end
            StAddr: w_state_d = StData;
            StData: begin
                w_colour_d = bus.rd_data;
                w_cnt_d    = ON_LOAD;
                w_state_d  = StOn;
            end
            StOn: begin
                if (r_cnt == '0) begin
                    w_cnt_d   = OFF_LOAD;
                    w_state_d = StOff;
                end else begin
                    w_cnt_d = r_cnt - CNT_ONE;
                end
            end
            StOff: begin
                if (r_cnt == '0) begin
                    if (r_idx == r_len - IDX_ONE) begin
                        w_state_d = StDone;
                    end else begin
                        w_idx_d   = r_idx + IDX_ONE;
                        w_state_d = StAddr;
                    end
                end else begin
                    w_cnt_d = r_cnt - CNT_ONE;
                end
            end
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase

        // Cancel overrides every transition while playing; IDLE and DONE ignore it.
        if (bus.abort && w_busy) begin
            w_state_d = StIdle;
        end
    end

    assign bus.rd_addr = r_idx[ADDR_W-1:0];
    assign bus.led     = (r_state == StOn) ? (4'b0001 << r_colour) : 4'b0000;
    assign bus.busy    = w_busy;
    assign bus.done    = (r_state == StDone);
endmodule

// File: tb/tb_led_sequence_player.sv
// Directed bench for led_sequence_player: a scenario table checked cycle by cycle
// against the documented timeline, plus hand-written reset corner cases.
module tb_led_sequence_player;
    localparam int unsigned A_ON = 8, A_OFF = 4, A_AW = 5;
    localparam int unsigned B_ON = 2, B_OFF = 1, B_AW = 2;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    logic [1:0] mem_a [32];
    logic [1:0] mem_b [4];

    led_sequence_player_if #(.ADDR_W(A_AW)) ifa ();
    led_sequence_player_if #(.ADDR_W(B_AW)) ifb ();

    led_sequence_player #(
        .ON_CYCLES (A_ON),
        .OFF_CYCLES(A_OFF),
        .ADDR_W    (A_AW)
    ) u_dut_a (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifa.slave)
    );

    led_sequence_player #(
        .ON_CYCLES (B_ON),
        .OFF_CYCLES(B_OFF),
        .ADDR_W    (B_AW)
    ) u_dut_b (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifb.slave)
    );

    always #5 clk = ~clk;

    // Sequence RAMs with one-cycle read latency.
    always_ff @(posedge clk) begin
        ifa.rd_data <= mem_a[ifa.rd_addr];
        ifb.rd_data <= mem_b[ifb.rd_addr];
    end

    typedef struct {
        int              sel;
        int              len;
        logic [3:0][1:0] col;
        int              abort_at;
        bit              poke;
    } scen_t;

    scen_t scen [7];

    task automatic chk(input string name, input int c, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic st, input logic ab, input int ln);
        if (sel == 0) begin
            ifa.start = st;
            ifa.abort = ab;
            ifa.len   = (A_AW + 1)'(ln);
        end else begin
            ifb.start = st;
            ifb.abort = ab;
            ifb.len   = (B_AW + 1)'(ln);
        end
    endtask

    task automatic run(input scen_t s);
        int unsigned on, off, per;
        int          done_c, last_c, step, ph;
        logic [3:0]  e_led;
        logic        e_busy, e_done, chk_addr;
        logic [31:0] a_led, a_busy, a_done, a_addr;
        on     = (s.sel == 0) ? A_ON : B_ON;
        off    = (s.sel == 0) ? A_OFF : B_OFF;
        per    = 2 + on + off;
        done_c = 1 + s.len * int'(per);
        last_c = (s.abort_at >= 0) ? s.abort_at + 2 : done_c + 3;
        for (int i = 0; i < s.len; i++) begin
            if (s.sel == 0) mem_a[i] = s.col[i];
            else            mem_b[i] = s.col[i];
        end
        for (int c = 0; c <= last_c; c++) begin
            @(posedge clk);
            #1;
            if (c == 0)                             drive(s.sel, 1'b1, 1'b0, s.len);
            else if (c == 1)                        drive(s.sel, 1'b0, 1'b0, s.len ^ 1);
            else if (s.poke && c == 5)              drive(s.sel, 1'b1, 1'b0, 1);
            else if (s.abort_at >= 0 && c == s.abort_at) drive(s.sel, 1'b0, 1'b1, 2);
            else                                    drive(s.sel, 1'b0, 1'b0, 3);
            @(negedge clk);
            e_led = 4'b0000; e_busy = 1'b0; e_done = 1'b0; chk_addr = 1'b0; step = 0;
            if (s.abort_at >= 0 && c > s.abort_at) begin
                e_busy = 1'b0;
            end else if (c >= 1 && c < done_c) begin
                e_busy   = 1'b1;
                step     = (c - 1) / int'(per);
                ph       = (c - 1) % int'(per);
                chk_addr = (ph < 2);
                if (ph >= 2 && ph <= int'(on) + 1) e_led = 4'(1 << s.col[step]);
            end else if (c == done_c) begin
                e_done = 1'b1;
            end
            a_led  = (s.sel == 0) ? 32'(ifa.led)     : 32'(ifb.led);
            a_busy = (s.sel == 0) ? 32'(ifa.busy)    : 32'(ifb.busy);
            a_done = (s.sel == 0) ? 32'(ifa.done)    : 32'(ifb.done);
            a_addr = (s.sel == 0) ? 32'(ifa.rd_addr) : 32'(ifb.rd_addr);
            chk("led", c, a_led, 32'(e_led));
            chk("busy", c, a_busy, 32'(e_busy));
            chk("done", c, a_done, 32'(e_done));
            if (chk_addr) chk("rd_addr", c, a_addr, 32'(step));
        end
        drive(s.sel, 1'b0, 1'b0, 0);
    endtask

    initial begin
        clk      = 1'b0;
        rst_n    = 1'b0;
        n_checks = 0;
        n_errors = 0;
        drive(0, 1'b0, 1'b0, 0);
        drive(1, 1'b0, 1'b0, 0);

        // Single step, the 3,0,1,2 sequence with an ignored start/len poke,
        // len=0, abort in step 2, replay, a 2-step run, and full length on ADDR_W=2.
        scen[0] = '{sel: 0, len: 1, col: {2'd0, 2'd0, 2'd0, 2'd2}, abort_at: -1, poke: 1'b0};
        scen[1] = '{sel: 0, len: 4, col: {2'd2, 2'd1, 2'd0, 2'd3}, abort_at: -1, poke: 1'b1};
        scen[2] = '{sel: 0, len: 0, col: {2'd0, 2'd0, 2'd0, 2'd0}, abort_at: -1, poke: 1'b0};
        scen[3] = '{sel: 0, len: 4, col: {2'd0, 2'd3, 2'd2, 2'd1}, abort_at: 21, poke: 1'b0};
        scen[4] = '{sel: 0, len: 4, col: {2'd0, 2'd3, 2'd2, 2'd1}, abort_at: -1, poke: 1'b0};
        scen[5] = '{sel: 0, len: 2, col: {2'd0, 2'd0, 2'd3, 2'd0}, abort_at: -1, poke: 1'b1};
        scen[6] = '{sel: 1, len: 4, col: {2'd3, 2'd2, 2'd1, 2'd0}, abort_at: -1, poke: 1'b0};

        #2;
        chk("reset_led", 0, 32'(ifa.led), 32'h0);
        chk("reset_busy", 0, 32'(ifa.busy), 32'h0);
        chk("reset_done", 0, 32'(ifa.done), 32'h0);
        chk("reset_addr", 0, 32'(ifa.rd_addr), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run(scen[i]);

        // Asynchronous reset in the OFF phase of step 2 of a len=2 run.
        mem_a[0] = 2'd1;
        mem_a[1] = 2'd3;
        @(posedge clk);
        #1;
        drive(0, 1'b1, 1'b0, 2);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 0);
        repeat (25) @(posedge clk);
        #3;
        chk("pre_reset_busy", 26, 32'(ifa.busy), 32'h1);
        chk("pre_reset_addr", 26, 32'(ifa.rd_addr), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("async_led", 26, 32'(ifa.led), 32'h0);
        chk("async_busy", 26, 32'(ifa.busy), 32'h0);
        chk("async_done", 26, 32'(ifa.done), 32'h0);
        chk("async_addr", 26, 32'(ifa.rd_addr), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_busy", 0, 32'(ifa.busy), 32'h0);
        chk("post_reset_done", 0, 32'(ifa.done), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/led_sequence_player.md
# led_sequence_player

Plays a stored Simon colour sequence on the four LEDs as one-hot pulses. It is the output-side counterpart of the button decoder: it maps 2-bit colour values back onto the same one-hot bit order, so a press of button N matches LED N. The block sits between the game FSM, which gives it a start/len request, and the sequence RAM, which it reads through a one-cycle-latency port.

## Interface
- ON_CYCLES, default 8: cycles each LED is lit per step; must be ≥1. The board top overrides it for visible timing.
- OFF_CYCLES, default 4: dark gap after each step; must be ≥1.
- ADDR_W, default 5: sequence RAM address width; maximum sequence length is 2^ADDR_W.
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request playback; sampled only in IDLE.
- abort  input  1  synchronous cancel of playback in progress.
- len  input  ADDR_W+1  number of steps to play, 0..2^ADDR_W; latched when start is accepted.
- rd_addr  output  ADDR_W  sequence RAM read address.
- rd_data  input  2  RAM data; valid the cycle after rd_addr is presented.
- led  output  4  one-hot colour: 0→0001, 1→0010, 2→0100, 3→1000; 0000 when dark.
- busy  output  1  high in ADDR, DATA, ON and OFF.
- done  output  1  one-cycle pulse when playback completes normally.

## Operation
- Registers:
  - state: IDLE, ADDR, DATA, ON, OFF, DONE.
  - idx: ADDR_W+1 bits.
  - len_q: latched length.
  - colour: 2 bits.
  - cnt: $clog2(max(ON_CYCLES, OFF_CYCLES)+1) bits.
- rd_addr = idx[ADDR_W-1:0], driven from the register and stable through ADDR and DATA.
- IDLE:
  - If start=1 and len≠0: latch len_q, set idx=0, go to ADDR.
  - If start=1 and len=0: go to DONE directly.
  - Otherwise stay in IDLE.
- ADDR: present rd_addr for one cycle, then go to DATA.
- DATA: capture colour ← rd_data at the end of the cycle, load cnt, go to ON.
- ON: led = onehot(colour) for exactly ON_CYCLES cycles, then reload cnt and go to OFF.
- OFF: led = 0000 for exactly OFF_CYCLES cycles. At the end:
  - If idx == len_q−1: go to DONE.
  - Otherwise idx ← idx+1 and go to ADDR.
- DONE: done=1 and busy=0 for one cycle, then go to IDLE.
- abort=1 in ADDR, DATA, ON or OFF:
  - Next state is IDLE with led=0000.
  - No done pulse.
  - abort takes priority over every other transition.
  - abort in IDLE or DONE has no effect; DONE still pulses.
- start is ignored outside IDLE. start and abort both high in IDLE: start wins, because abort is a no-op in IDLE.
- len changing after acceptance has no effect.
- Maximum length 2^ADDR_W: idx reaches 2^ADDR_W−1 with no wrap, and playback ends after that step.

## Timing
- Reset (asynchronous, immediate, including mid-playback):
  - state=IDLE, idx=0, cnt=0, colour=0.
  - led=0000, busy=0, done=0, rd_addr=0.
- All outputs are registered or decoded from state/registers only. There are no combinational paths from inputs to outputs.
- start is high in cycle 0. Then:
  - Cycle 1: ADDR.
  - Cycle 2: DATA.
  - Cycles 3..ON_CYCLES+2: LED lit.
  - Next OFF_CYCLES cycles: dark.
- Per-step period is 2+ON_CYCLES+OFF_CYCLES cycles.
- done is high in cycle 1+len·(2+ON_CYCLES+OFF_CYCLES). With len=0, done is high in cycle 1.
- The earliest next start is accepted in the cycle after done.

## Test plan
- Single step with defaults: RAM[0]=2, start with len=1 at cycle 0.
  - led=0100 in cycles 3..10; 0000 in cycles 11..14.
  - done=1 only in cycle 15.
  - busy=1 in cycles 1..14.
- Sequence 3,0,1,2 with len=4:
  - led shows 1000, 0001, 0010, 0100, with each lit phase starting 14 cycles apart.
  - rd_addr steps 0,1,2,3.
  - done=1 in cycle 57.
- len=0 start: done=1 in cycle 1, busy never rises, led stays 0000.
- abort in the 5th ON cycle of step 2 of a len=4 sequence:
  - Next cycle is IDLE, led=0000, busy=0.
  - No done pulse.
  - A new start 1 cycle later replays from RAM[0].
- Assert rst_n=0 mid-OFF: led, busy, done and rd_addr all go to 0 immediately, without waiting for clk. start is ignored while busy; len is changed mid-play with no effect.
- ADDR_W=2, len=4 (full): all 4 addresses are read, idx does not wrap, done fires once.
